// File: rtl/tick_period_meter_if.sv
// rtl/tick_period_meter_if.sv - strobe input and period measurement results bundle
interface tick_period_meter_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             tick;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             locked;

  modport master (
    output en, tick,
    input  period, period_valid, timeout, locked
  );

  modport slave (
    input  en, tick,
    output period, period_valid, timeout, locked
  );
endinterface

// File: rtl/tick_period_meter_match.sv
// rtl/tick_period_meter_match.sv - combinational |a-b| <= TOL stability compare
module period_match #(
  parameter int WIDTH = 16,
  parameter int TOL   = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             match_o
);
  localparam logic [WIDTH:0] TOL_W = (WIDTH + 1)'(TOL);

  logic [WIDTH:0] diff;

  // Absolute difference one bit wider than the operands so it never wraps
  always_comb begin
    if (a_i >= b_i) diff = {1'b0, a_i} - {1'b0, b_i};
    else            diff = {1'b0, b_i} - {1'b0, a_i};
    match_o = (diff <= TOL_W);
  end
endmodule

// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - measures clk cycles between strobes, flags timeout and lock
module tick_period_meter #(
  parameter int WIDTH      = 16,
  parameter int MAX_PERIOD = 65535,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic               clk,
  input  logic               rst,
  tick_period_meter_if.slave bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_PERIOD);
  localparam logic [MW-1:0]    LOCK_W = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [MW-1:0]    match_inc;
  logic             first_q, first_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic             is_match;

  // The new period is the running count; compare it against the previous one
  period_match #(.WIDTH(WIDTH), .TOL(TOL)) u_match (
    .a_i     (cnt_q),
    .b_i     (prev_q),
    .match_o (is_match)
  );

  assign match_inc = (match_q == LOCK_W) ? match_q : match_q + MW'(1);

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.locked       = locked_q;

  // State and measurement registers; reset discards any measurement in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      prev_q    <= '0;
      match_q   <= '0;
      first_q   <= 1'b1;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
    end
  end

  // Next state: disable overrides everything, a tick beats a coincident timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    prev_d    = prev_q;
    match_d   = match_q;
    first_d   = first_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    locked_d  = locked_q;
    if (!bus.en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      match_d   = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
      first_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (bus.tick) begin
            cnt_d     = WIDTH'(1);
            timeout_d = 1'b0;
            first_d   = 1'b1;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          if (bus.tick) begin
            period_d = cnt_q;
            prev_d   = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = WIDTH'(1);
            first_d  = 1'b0;
            if (first_q) begin
              match_d = '0;
            end else if (is_match) begin
              match_d = match_inc;
              if (match_inc == LOCK_W) locked_d = 1'b1;
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == MAX_W) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            cnt_d     = '0;
            state_d   = ARMED;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
